// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the Starflux scoreboard.
// Holds the game state enum, the LED pattern index type and the
// active-low 7-segment lookup table (segment order {g,f,e,d,c,b,a}).
package scoreboard_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  typedef logic [1:0] pat_idx_t;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b100_0000,  // 0
    7'b111_1001,  // 1
    7'b010_0100,  // 2
    7'b011_0000,  // 3
    7'b001_1001,  // 4
    7'b001_0010,  // 5
    7'b000_0010,  // 6
    7'b111_1000,  // 7
    7'b000_0000,  // 8
    7'b001_0000,  // 9
    7'b000_1000,  // A
    7'b000_0011,  // b
    7'b100_0110,  // C
    7'b010_0001,  // d
    7'b000_0110,  // E
    7'b000_1110   // F
  };

endpackage

// File: rtl/scoreboard_ctrl_seg7_digit.sv
// Single hex digit to active-low 7-segment decoder, purely combinational.
module seg7_digit
  import scoreboard_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[value];

endmodule

// File: rtl/scoreboard_ctrl.sv
// Starflux game scoreboard: score counter, best-score register, health
// counter, game-over detection and a game-over LED flash sequencer.
// Optional build macro SCOREBOARD_BCD_EN: score counts in decimal digits
// and saturates at all nines; otherwise plain binary saturating at all ones.
module scoreboard_ctrl
  import scoreboard_pkg::*;
#(
  parameter int SCORE_DIGITS = 2,
  parameter int HEALTH_MAX   = 15,
  parameter int FLASH_DIV    = 25000000,
  parameter int LEDR_W       = 18,
  parameter int LEDG_W       = 9
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      score_inc,
  input  logic                      hit,
  input  logic                      new_game,
  output logic [7*SCORE_DIGITS-1:0] hex_score,
  output logic [7*SCORE_DIGITS-1:0] hex_best,
  output logic [6:0]                hex_health,
  output logic [3:0]                health_out,
  output logic                      game_over,
  output logic [LEDR_W-1:0]         ledr,
  output logic [LEDG_W-1:0]         ledg
);

  localparam int SW    = 4 * SCORE_DIGITS;
  localparam int CNT_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(FLASH_DIV - 1);
  localparam logic [3:0]       HEALTH_INIT = 4'(HEALTH_MAX);

  state_t           state;
  logic [SW-1:0]    score;
  logic [SW-1:0]    best;
  logic [3:0]       health;
  logic [CNT_W-1:0] flash_cnt;
  pat_idx_t         pat_idx;

  logic [SW-1:0]    score_next;
  logic [SW-1:0]    best_vs_score;
  logic [SW-1:0]    best_vs_next;

  // Saturating increment; BCD mode ripples a decimal carry digit by digit.
  function automatic logic [SW-1:0] score_incr(input logic [SW-1:0] s);
`ifdef SCOREBOARD_BCD_EN
    logic [SW-1:0] r;
    logic          carry;
    logic          sat;
    r     = s;
    carry = 1'b1;
    sat   = 1'b1;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      if (s[4*d +: 4] != 4'd9) sat = 1'b0;
    end
    if (!sat) begin
      for (int d = 0; d < SCORE_DIGITS; d++) begin
        if (carry) begin
          if (r[4*d +: 4] == 4'd9) begin
            r[4*d +: 4] = 4'd0;
          end else begin
            r[4*d +: 4] = r[4*d +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
`else
    return (&s) ? s : s + SW'(1);
`endif
  endfunction

  // Red LED pattern for a given step: alternating (MSB set), inverse, ones, zeros.
  function automatic logic [LEDR_W-1:0] pat_r(input pat_idx_t idx);
    logic [LEDR_W-1:0] alt;
    for (int i = 0; i < LEDR_W; i++) alt[i] = (((LEDR_W - 1 - i) % 2) == 0);
    case (idx)
      2'd0:    return alt;
      2'd1:    return ~alt;
      2'd2:    return '1;
      default: return '0;
    endcase
  endfunction

  // Green LED pattern, same sequence at the green width.
  function automatic logic [LEDG_W-1:0] pat_g(input pat_idx_t idx);
    logic [LEDG_W-1:0] alt;
    for (int i = 0; i < LEDG_W; i++) alt[i] = (((LEDG_W - 1 - i) % 2) == 0);
    case (idx)
      2'd0:    return alt;
      2'd1:    return ~alt;
      2'd2:    return '1;
      default: return '0;
    endcase
  endfunction

  // Score after this cycle's increment, and the two candidate best values.
  always_comb begin
    score_next    = score_inc ? score_incr(score) : score;
    best_vs_score = (score >= best) ? score : best;
    best_vs_next  = (score_next >= best) ? score_next : best;
  end

  // Game FSM with score, health, best and flash sequencer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= PLAY;
      score     <= '0;
      best      <= '0;
      health    <= HEALTH_INIT;
      game_over <= 1'b0;
      ledr      <= '0;
      ledg      <= '0;
      flash_cnt <= '0;
      pat_idx   <= '0;
    end else if (new_game) begin
      // Restart wins over any simultaneous point or hit.
      best      <= best_vs_score;
      score     <= '0;
      health    <= HEALTH_INIT;
      state     <= PLAY;
      game_over <= 1'b0;
      ledr      <= '0;
      ledg      <= '0;
      flash_cnt <= '0;
      pat_idx   <= '0;
    end else if (state == PLAY) begin
      score <= score_next;
      if (hit) begin
        if (health <= 4'd1) begin
          // Fatal hit: best sees the score including a same-cycle point.
          health    <= 4'd0;
          state     <= OVER;
          game_over <= 1'b1;
          best      <= best_vs_next;
          ledr      <= pat_r(2'd0);
          ledg      <= pat_g(2'd0);
          flash_cnt <= '0;
          pat_idx   <= '0;
        end else begin
          health <= health - 4'd1;
        end
      end
    end else begin
      if (flash_cnt == CNT_LAST) begin
        flash_cnt <= '0;
        pat_idx   <= pat_idx_t'(pat_idx + 2'd1);
        ledr      <= pat_r(pat_idx_t'(pat_idx + 2'd1));
        ledg      <= pat_g(pat_idx_t'(pat_idx + 2'd1));
      end else begin
        flash_cnt <= flash_cnt + CNT_W'(1);
      end
    end
  end

  assign health_out = health;

  for (genvar g = 0; g < SCORE_DIGITS; g++) begin : g_digits
    seg7_digit u_score_dig (
      .value (score[4*g +: 4]),
      .seg   (hex_score[7*g +: 7])
    );
    seg7_digit u_best_dig (
      .value (best[4*g +: 4]),
      .seg   (hex_best[7*g +: 7])
    );
  end

  seg7_digit u_health_dig (
    .value (health),
    .seg   (hex_health)
  );

endmodule

// File: doc/scoreboard_ctrl.md
Name: scoreboard_ctrl

Overview:
Parametrised game scoreboard for the Starflux board top level. It covers the current score counter, the best-score register, the health counter, and game-over detection. A game-over LED flash sequencer drives the red and green LEDs. All 7-segment outputs are active-low and decoded from registered state; the top level only routes pulses in and segments/LEDs out.

Parameters:
- SCORE_DIGITS, 2: number of 4-bit score digits; the score register is 4*SCORE_DIGITS bits wide.
- HEALTH_MAX, 15: health value after reset and after new_game; range 1..15.
- FLASH_DIV, 25000000: clk cycles per LED pattern step in game-over (0.5 s at 50 MHz); minimum 1.
- LEDR_W, 18: red LED count.
- LEDG_W, 9: green LED count.

Ports:
- clk  in  1  system clock (50 MHz).
- resetn  in  1  asynchronous, active-low reset.
- score_inc  in  1  single-cycle pulse; add one point.
- hit  in  1  single-cycle pulse; lose one health.
- new_game  in  1  single-cycle pulse; restart the game.
- hex_score  out  7*SCORE_DIGITS  current score segments; digit 0 in bits [6:0].
- hex_best  out  7*SCORE_DIGITS  best score segments, same packing.
- hex_health  out  7  health digit segments.
- health_out  out  4  raw health value.
- game_over  out  1  high while in state OVER.
- ledr  out  LEDR_W  red LEDs.
- ledg  out  LEDG_W  green LEDs.

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low; all registers clear immediately on assertion.
- Reset values:
  - score = 0, best = 0, health = HEALTH_MAX.
  - state = PLAY, game_over = 0, ledr = 0, ledg = 0.
  - flash counter = 0, pattern index = 0.
- Latency: register updates occur on the clk edge that samples the pulse. Segment outputs are combinational from registers, so they are valid in the following cycle.
- FSM, two states:
  - PLAY:
    - score_inc increments score, saturating at all-ones (0xFF for 2 digits); it never wraps.
    - hit decrements health.
    - A hit with health == 1 sets health = 0, enters OVER and updates best in the same edge.
  - OVER:
    - score_inc and hit are ignored; health stays 0.
    - Flash sequencer runs.
- Simultaneous events in PLAY:
  - score_inc and hit together: both apply. If the hit is fatal, best compares against the incremented score.
  - new_game has priority over score_inc and hit in any state.
- new_game:
  - best <= max(best, score) using the pre-clear score.
  - score <= 0, health <= HEALTH_MAX, state <= PLAY.
  - ledr/ledg <= 0; flash counter and pattern index cleared.
- Best score: compared with >= unsigned over the full width. It is cleared only by resetn.
- Flash sequencer (OVER only):
  - Counter counts 0..FLASH_DIV-1.
  - On terminal count, pattern index advances 0→1→2→3→0.
  - Pattern 0: bits alternate 1010…, MSB = 1. Pattern 1: bitwise inverse of pattern 0. Pattern 2: all ones. Pattern 3: all zeros.
  - Applied to ledr and ledg, each at its own width.
  - Pattern 0 is shown on the first cycle after entering OVER.
- Health display: hex_health shows health as a hex digit; 0 shows "0".
- Reset mid-game: resetn low at any time returns all outputs to their reset values asynchronously, including clearing best.

Optional Feature:
- SCOREBOARD_BCD_EN defined:
  - score counts in decimal per digit with carry; digits 0–9 only.
  - score saturates at all nines (99 for 2 digits).
  - best comparison uses the same BCD encoding, which is order-preserving.
- Undefined: score counts in plain binary and saturates at all-ones; digits show 0–F.

Decomposition:
- Shared package scoreboard_pkg:
  - state enum {PLAY, OVER}.
  - 16-entry active-low segment constant table.
  - LED pattern index type (2 bits).
- One sub-module, seg7_digit: 4-bit in, 7-bit active-low out, purely combinational.
  - Instantiated 2*SCORE_DIGITS+1 times.
- Score increment, BCD carry and flash logic stay inline.

Test Plan:
1. Reset then 0x12 score_inc pulses → hex_score digit1 = 7'b111_1001 ("1"), digit0 = 7'b010_0100 ("2"); health_out = 15; ledr = 0.
2. 15 hit pulses → health_out = 0, game_over = 1 on the 15th edge; best = current score; later score_inc/hit pulses leave score and health unchanged.
3. With FLASH_DIV = 4 in OVER:
   - ledr = 18'b10_1010_1010_1010_1010 for 4 cycles, then its inverse, then all ones, then all zeros, then pattern 0 again.
   - ledg follows the same patterns at 9 bits (9'b1_0101_0101 first).
4. 300 score_inc pulses without SCOREBOARD_BCD_EN → score = 0xFF held. With the macro: 105 pulses → display "99" held.
5. score_inc, fatal hit and new_game in the same cycle → new_game wins: score = 0, health = 15, PLAY, best = old score.
6. resetn low mid-flash for 1 cycle → ledr, ledg, game_over, best and score read 0 before the next clk edge; health_out = 15.
